// File: rtl/avmm_mem_responder.sv
// avmm_mem_responder: Avalon-MM slave memory with byte-enabled writes, fixed-latency
// in-order pipelined reads, programmable wait states and outstanding-read backpressure.
module avmm_mem_responder #(
    parameter int ADDR_W       = 12,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_CYCLES  = 1,
    parameter int MAX_PEND     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    input  logic [3:0]        slave_byteenable,
    output logic              slave_waitrequest,
    output logic [31:0]       slave_readdata,
    output logic              slave_readdatavalid,
    input  logic              stall_en,
    output logic [3:0]        pending,
    output logic              proto_err
);
    typedef enum logic {IDLE, STALL} state_t;
    localparam bit HAS_WAIT = WAIT_CYCLES > 0;
    state_t state;
    logic [3:0] cnt;
    logic [31:0] mem [2**ADDR_W];
    logic [READ_LATENCY-1:0] vpipe;
    logic [READ_LATENCY-1:0][31:0] dpipe;
    logic cmd, rd, fsm_wait, full, accept, rd_acc, wr_acc;
    assign cmd = slave_read | slave_write;
    // read and write together is handled as a write only
    assign rd = slave_read & ~slave_write;
    assign full = pending == 4'(MAX_PEND);
    assign fsm_wait = (state == STALL) ? (cnt != 4'd0) : (cmd && stall_en && HAS_WAIT);
    assign slave_waitrequest = fsm_wait | (rd & full);
    assign accept = cmd & ~slave_waitrequest;
    assign rd_acc = accept & rd;
    assign wr_acc = accept & slave_write;
    assign slave_readdatavalid = vpipe[READ_LATENCY-1];
    assign slave_readdata = dpipe[READ_LATENCY-1];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
        end else if (state == IDLE) begin
            if (cmd && stall_en && HAS_WAIT) begin
                state <= STALL;
                cnt <= 4'(WAIT_CYCLES - 1);
            end
        end else if (!cmd || accept) begin
            state <= IDLE;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    always_ff @(posedge clk)
        if (wr_acc) begin
            if (slave_byteenable[0]) mem[slave_address][7:0]   <= slave_writedata[7:0];
            if (slave_byteenable[1]) mem[slave_address][15:8]  <= slave_writedata[15:8];
            if (slave_byteenable[2]) mem[slave_address][23:16] <= slave_writedata[23:16];
            if (slave_byteenable[3]) mem[slave_address][31:24] <= slave_writedata[31:24];
        end
    // each data stage only advances with a valid beat, so the output stage holds the last return
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vpipe <= '0;
            dpipe <= '0;
        end else begin
            vpipe[0] <= rd_acc;
            if (rd_acc) dpipe[0] <= mem[slave_address];
            for (int i = 1; i < READ_LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
                if (vpipe[i-1]) dpipe[i] <= dpipe[i-1];
            end
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pending <= '0;
            proto_err <= 1'b0;
        end else begin
            pending <= pending + 4'(rd_acc) - 4'(slave_readdatavalid);
            proto_err <= proto_err | (slave_read & slave_write);
        end
endmodule
